// File: rtl/alu_operand_stage.sv
// ID/EX pipeline stage for the 64-bit ALU: registers decoded operands and control,
// decodes ALUCtrl, and forwards EX/MEM and MEM/WB results into the operand buses.
module alu_operand_stage #(
  parameter int n  = 64,
  parameter int ZR = 31
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         Stall,
  input  logic         Flush,
  input  logic         IdValid,
  input  logic [n-1:0] IdBusA,
  input  logic [n-1:0] IdBusB,
  input  logic [n-1:0] IdImm64,
  input  logic [5:0]   IdShamt,
  input  logic         IdALUSrc,
  input  logic [1:0]   IdALUOp,
  input  logic [10:0]  IdOpcode,
  input  logic [4:0]   IdRn,
  input  logic [4:0]   IdRm,
  input  logic [4:0]   IdRd,
  input  logic         IdRegWrite,
  input  logic         ExMemRegWrite,
  input  logic         MemWbRegWrite,
  input  logic [4:0]   ExMemRd,
  input  logic [4:0]   MemWbRd,
  input  logic [n-1:0] ExMemResult,
  input  logic [n-1:0] MemWbResult,
  output logic [n-1:0] BusA,
  output logic [n-1:0] BusB,
  output logic [n-1:0] StoreData,
  output logic [3:0]   ALUCtrl,
  output logic [4:0]   ExRd,
  output logic         ExRegWrite,
  output logic         ExValid,
  output logic         IllegalOp
);

  typedef enum logic [3:0] {
    CTRL_AND   = 4'b0000,
    CTRL_ORR   = 4'b0001,
    CTRL_ADD   = 4'b0010,
    CTRL_LSL   = 4'b0011,
    CTRL_LSR   = 4'b0100,
    CTRL_SUB   = 4'b0110,
    CTRL_PASSB = 4'b0111
  } aluCtrl_e;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;

  localparam logic [4:0] ZR_IDX = 5'(ZR);

  // Stage registers
  logic         exValid;
  logic         exRegWrite;
  logic         exIllegal;
  logic         exAluSrc;
  aluCtrl_e     exCtrl;
  logic [4:0]   exRn;
  logic [4:0]   exRm;
  logic [4:0]   exRd;
  logic [5:0]   exShamt;
  logic [n-1:0] exBusA;
  logic [n-1:0] exBusB;
  logic [n-1:0] exImm;

  // Decode results for the instruction currently in ID
  aluCtrl_e decCtrl;
  logic     decIllegal;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    decCtrl    = CTRL_AND;
    decIllegal = 1'b0;
    unique case (IdALUOp)
      2'b00: decCtrl = CTRL_ADD;
      2'b01: decCtrl = CTRL_PASSB;
      2'b10: begin
        case (IdOpcode)
          OP_ADD:  decCtrl = CTRL_ADD;
          OP_SUB:  decCtrl = CTRL_SUB;
          OP_AND:  decCtrl = CTRL_AND;
          OP_ORR:  decCtrl = CTRL_ORR;
          OP_LSL:  decCtrl = CTRL_LSL;
          OP_LSR:  decCtrl = CTRL_LSR;
          default: decIllegal = 1'b1;
        endcase
      end
      default: decIllegal = 1'b1;
    endcase
  end

  // Flush beats Stall beats load; a flushed slot is cleared entirely.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exIllegal  <= 1'b0;
      exAluSrc   <= 1'b0;
      exCtrl     <= CTRL_AND;
      exRn       <= '0;
      exRm       <= '0;
      exRd       <= '0;
      exShamt    <= '0;
      exBusA     <= '0;
      exBusB     <= '0;
      exImm      <= '0;
    end else if (Flush) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exIllegal  <= 1'b0;
      exAluSrc   <= 1'b0;
      exCtrl     <= CTRL_AND;
      exRn       <= '0;
      exRm       <= '0;
      exRd       <= '0;
      exShamt    <= '0;
      exBusA     <= '0;
      exBusB     <= '0;
      exImm      <= '0;
    end else if (!Stall) begin
      exValid    <= IdValid;
      exRegWrite <= IdRegWrite & IdValid;
      exIllegal  <= decIllegal & IdValid;
      exAluSrc   <= IdALUSrc;
      exCtrl     <= decCtrl;
      exRn       <= IdRn;
      exRm       <= IdRm;
      exRd       <= IdRd;
      exShamt    <= IdShamt;
      exBusA     <= IdBusA;
      exBusB     <= IdBusB;
      exImm      <= IdImm64;
    end
  end

  // EX/MEM has priority over MEM/WB; XZR and empty slots never forward.
  function automatic logic [n-1:0] forward(
    input logic [4:0]   src,
    input logic [n-1:0] regVal,
    input logic         slotValid,
    input logic         exMemWr,
    input logic [4:0]   exMemDst,
    input logic [n-1:0] exMemVal,
    input logic         memWbWr,
    input logic [4:0]   memWbDst,
    input logic [n-1:0] memWbVal
  );
    logic [n-1:0] result;
    result = regVal;
    if (slotValid && src != ZR_IDX) begin
      if (exMemWr && exMemDst == src)
        result = exMemVal;
      else if (memWbWr && memWbDst == src)
        result = memWbVal;
    end
    return result;
  endfunction

  logic [n-1:0] fwdA;
  logic [n-1:0] fwdB;

  assign fwdA = forward(exRn, exBusA, exValid, ExMemRegWrite, ExMemRd, ExMemResult,
                        MemWbRegWrite, MemWbRd, MemWbResult);
  assign fwdB = forward(exRm, exBusB, exValid, ExMemRegWrite, ExMemRd, ExMemResult,
                        MemWbRegWrite, MemWbRd, MemWbResult);

  always_comb begin
    BusB = fwdB;
    if (exCtrl == CTRL_LSL || exCtrl == CTRL_LSR)
      BusB = {{(n-6){1'b0}}, exShamt};
    else if (exAluSrc)
      BusB = exImm;
  end

  assign BusA       = fwdA;
  assign StoreData  = fwdB;
  assign ALUCtrl    = exCtrl;
  assign ExRd       = exRd;
  assign ExRegWrite = exRegWrite;
  assign ExValid    = exValid;
  assign IllegalOp  = exIllegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage: decode, forwarding, stall/flush, reset.
module tb_alu_operand_stage;

  logic        CLK;
  logic        Reset_L;
  logic        Stall;
  logic        Flush;
  logic        IdValid;
  logic [63:0] IdBusA;
  logic [63:0] IdBusB;
  logic [63:0] IdImm64;
  logic [5:0]  IdShamt;
  logic        IdALUSrc;
  logic [1:0]  IdALUOp;
  logic [10:0] IdOpcode;
  logic [4:0]  IdRn;
  logic [4:0]  IdRm;
  logic [4:0]  IdRd;
  logic        IdRegWrite;
  logic        ExMemRegWrite;
  logic        MemWbRegWrite;
  logic [4:0]  ExMemRd;
  logic [4:0]  MemWbRd;
  logic [63:0] ExMemResult;
  logic [63:0] MemWbResult;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [63:0] StoreData;
  logic [3:0]  ALUCtrl;
  logic [4:0]  ExRd;
  logic        ExRegWrite;
  logic        ExValid;
  logic        IllegalOp;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.n(64), .ZR(31)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
    .IdBusA(IdBusA), .IdBusB(IdBusB), .IdImm64(IdImm64), .IdShamt(IdShamt),
    .IdALUSrc(IdALUSrc), .IdALUOp(IdALUOp), .IdOpcode(IdOpcode),
    .IdRn(IdRn), .IdRm(IdRm), .IdRd(IdRd), .IdRegWrite(IdRegWrite),
    .ExMemRegWrite(ExMemRegWrite), .MemWbRegWrite(MemWbRegWrite),
    .ExMemRd(ExMemRd), .MemWbRd(MemWbRd), .ExMemResult(ExMemResult), .MemWbResult(MemWbResult),
    .BusA(BusA), .BusB(BusB), .StoreData(StoreData), .ALUCtrl(ALUCtrl), .ExRd(ExRd),
    .ExRegWrite(ExRegWrite), .ExValid(ExValid), .IllegalOp(IllegalOp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic loadOp(input logic valid, input logic [1:0] aluOp, input logic [10:0] opcode,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                        input logic [5:0] shamt, input logic aluSrc, input logic regWrite);
    IdValid    = valid;
    IdALUOp    = aluOp;
    IdOpcode   = opcode;
    IdRn       = rn;
    IdRm       = rm;
    IdRd       = rd;
    IdBusA     = a;
    IdBusB     = b;
    IdImm64    = imm;
    IdShamt    = shamt;
    IdALUSrc   = aluSrc;
    IdRegWrite = regWrite;
  endtask

  task automatic clearFwd();
    ExMemRegWrite = 1'b0;
    MemWbRegWrite = 1'b0;
    ExMemRd       = '0;
    MemWbRd       = '0;
    ExMemResult   = '0;
    MemWbResult   = '0;
  endtask

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;

  initial begin
    Reset_L = 1'b0;
    Stall   = 1'b0;
    Flush   = 1'b0;
    loadOp(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    clearFwd();
    step();
    step();

    check("reset ExValid", 64'(ExValid), 64'd0);
    check("reset ExRegWrite", 64'(ExRegWrite), 64'd0);
    check("reset ALUCtrl", 64'(ALUCtrl), 64'd0);
    check("reset BusA", BusA, 64'd0);
    check("reset BusB", BusB, 64'd0);
    Reset_L = 1'b1;

    // ADD X1,X2,X3 with A=5, B=7, no hazards
    loadOp(1'b1, 2'b10, OP_ADD, 5'd2, 5'd3, 5'd1, 64'd5, 64'd7, 64'd0, 6'd0, 1'b0, 1'b1);
    step();
    check("add ALUCtrl", 64'(ALUCtrl), 64'b0010);
    check("add BusA", BusA, 64'd5);
    check("add BusB", BusB, 64'd7);
    check("add StoreData", StoreData, 64'd7);
    check("add ExRd", 64'(ExRd), 64'd1);
    check("add ExRegWrite", 64'(ExRegWrite), 64'd1);
    check("add ExValid", 64'(ExValid), 64'd1);
    check("add IllegalOp", 64'(IllegalOp), 64'd0);

    // Same-cycle forwarding onto the held ADD (Rn=2, Rm=3)
    Stall = 1'b1;
    ExMemRegWrite = 1'b1; ExMemRd = 5'd2; ExMemResult = 64'hAA;
    MemWbRegWrite = 1'b1; MemWbRd = 5'd2; MemWbResult = 64'hBB;
    #1 check("fwd exmem wins", BusA, 64'hAA);
    ExMemRegWrite = 1'b0;
    #1 check("fwd memwb", BusA, 64'hBB);
    MemWbRd = 5'd3;
    #1 check("fwd memwb Rm BusB", BusB, 64'hBB);
    check("fwd memwb Rm StoreData", StoreData, 64'hBB);
    check("fwd Rn no match", BusA, 64'd5);
    clearFwd();
    Stall = 1'b0;

    // Rn = XZR must not be forwarded
    loadOp(1'b1, 2'b10, OP_ADD, 5'd31, 5'd3, 5'd4, 64'd0, 64'd1, 64'd0, 6'd0, 1'b0, 1'b1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd31; ExMemResult = 64'hFF;
    step();
    check("xzr BusA", BusA, 64'd0);
    check("xzr BusB", BusB, 64'd1);
    clearFwd();

    // LSL: BusB is the shift amount
    loadOp(1'b1, 2'b10, OP_LSL, 5'd4, 5'd31, 5'd5, 64'd1, 64'h1234, 64'd0, 6'd4, 1'b0, 1'b1);
    step();
    check("lsl ALUCtrl", 64'(ALUCtrl), 64'b0011);
    check("lsl BusA", BusA, 64'd1);
    check("lsl BusB", BusB, 64'd4);

    // STUR: immediate on BusB, forwarded Rm on StoreData
    loadOp(1'b1, 2'b00, 11'b11111000000, 5'd5, 5'd6, 5'd6, 64'h100, 64'h33, 64'd8, 6'd0, 1'b1, 1'b0);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd6; ExMemResult = 64'h77;
    step();
    check("stur ALUCtrl", 64'(ALUCtrl), 64'b0010);
    check("stur BusB", BusB, 64'd8);
    check("stur StoreData", StoreData, 64'h77);
    check("stur BusA", BusA, 64'h100);
    check("stur ExRegWrite", 64'(ExRegWrite), 64'd0);
    clearFwd();

    // Remaining decodes
    loadOp(1'b1, 2'b01, '0, 5'd1, 5'd2, 5'd3, 64'd0, 64'd9, 64'd0, 6'd0, 1'b0, 1'b1);
    step();
    check("passb ALUCtrl", 64'(ALUCtrl), 64'b0111);
    IdALUOp = 2'b10; IdOpcode = OP_SUB;
    step();
    check("sub ALUCtrl", 64'(ALUCtrl), 64'b0110);
    IdOpcode = OP_AND;
    step();
    check("and ALUCtrl", 64'(ALUCtrl), 64'b0000);
    check("and IllegalOp", 64'(IllegalOp), 64'd0);
    IdOpcode = OP_ORR;
    step();
    check("orr ALUCtrl", 64'(ALUCtrl), 64'b0001);
    IdOpcode = OP_LSR; IdShamt = 6'd63;
    step();
    check("lsr ALUCtrl", 64'(ALUCtrl), 64'b0100);
    check("lsr BusB", BusB, 64'd63);
    IdOpcode = 11'b10001011001;
    step();
    check("bad opcode IllegalOp", 64'(IllegalOp), 64'd1);
    check("bad opcode ALUCtrl", 64'(ALUCtrl), 64'b0000);
    IdALUOp = 2'b11; IdOpcode = OP_ADD;
    step();
    check("aluop11 IllegalOp", 64'(IllegalOp), 64'd1);
    check("aluop11 ALUCtrl", 64'(ALUCtrl), 64'b0000);

    // Invalid slot: no IllegalOp, no RegWrite, no forwarding
    loadOp(1'b0, 2'b11, OP_ADD, 5'd2, 5'd3, 5'd7, 64'h44, 64'h55, 64'd0, 6'd0, 1'b0, 1'b1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd2; ExMemResult = 64'hEE;
    step();
    check("invalid ExValid", 64'(ExValid), 64'd0);
    check("invalid ExRegWrite", 64'(ExRegWrite), 64'd0);
    check("invalid IllegalOp", 64'(IllegalOp), 64'd0);
    check("invalid no fwd", BusA, 64'h44);
    clearFwd();

    // Stall holds the stage while ID changes underneath
    loadOp(1'b1, 2'b10, OP_ORR, 5'd7, 5'd8, 5'd9, 64'h11, 64'h22, 64'd0, 6'd0, 1'b0, 1'b1);
    step();
    Stall = 1'b1;
    loadOp(1'b1, 2'b10, OP_SUB, 5'd1, 5'd2, 5'd3, 64'h99, 64'h88, 64'd0, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall ALUCtrl", 64'(ALUCtrl), 64'b0001);
      check("stall BusA", BusA, 64'h11);
      check("stall ExRd", 64'(ExRd), 64'd9);
    end
    ExMemRegWrite = 1'b1; ExMemRd = 5'd7; ExMemResult = 64'h5A;
    #1 check("stall fwd tracks", BusA, 64'h5A);
    clearFwd();
    Flush = 1'b1;
    step();
    check("stall+flush ExValid", 64'(ExValid), 64'd0);
    check("stall+flush ExRegWrite", 64'(ExRegWrite), 64'd0);
    Flush = 1'b0;
    Stall = 1'b0;

    // Asynchronous reset between edges clears the outputs at once
    loadOp(1'b1, 2'b10, OP_LSL, 5'd1, 5'd2, 5'd1, 64'h12, 64'h34, 64'h56, 6'd5, 1'b1, 1'b1);
    step();
    check("pre-reset ExValid", 64'(ExValid), 64'd1);
    ExMemRegWrite = 1'b1; ExMemRd = 5'd0; ExMemResult = 64'hFF;
    #1 Reset_L = 1'b0;
    #1;
    check("async reset ExValid", 64'(ExValid), 64'd0);
    check("async reset ExRegWrite", 64'(ExRegWrite), 64'd0);
    check("async reset ExRd", 64'(ExRd), 64'd0);
    check("async reset ALUCtrl", 64'(ALUCtrl), 64'd0);
    check("async reset BusA", BusA, 64'd0);
    check("async reset BusB", BusB, 64'd0);
    check("async reset StoreData", StoreData, 64'd0);
    step();
    Reset_L = 1'b1;
    clearFwd();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
